// File: rtl/da_stream_ctrl.sv
// rtl/da_stream_ctrl.sv - DAC0808 sample streaming controller
// Bus-written sample FIFO drained onto the DAC pins at a programmable rate.
module da_stream_ctrl #(
  parameter logic [9:0] BASE       = 10'h1F8,
  parameter int         DEPTH_LOG2 = 4,
  parameter int         DIV_W      = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AEN,
  input  logic [9:0] A,
  input  logic       IOR,
  input  logic       IOW,
  input  logic [7:0] DATAIN,
  output logic [7:0] DATAOUT,
  output logic [7:0] OUT,
  output logic       IRQ
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  run_q, run_d;
  logic                  underrun_q, underrun_d;
  logic                  irq_q, irq_d;
  logic [7:0]            out_q, out_d;
  logic                  iow_prev_q, iow_prev_d;
  logic                  ior_prev_q, ior_prev_d;
  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [9:0]  a_rel;
  logic        sel;
  logic [1:0]  off;
  logic        wr_evt, rd_evt;
  logic        wr_data, wr_ctrl, start, stop, flush;
  logic        full, empty, tick, pop, push;
  logic [15:0] div_wide;
  logic [7:0]  status;

  assign a_rel   = A - BASE;
  assign sel     = AEN && (a_rel < 10'd4);
  assign off     = a_rel[1:0];
  // Strobes are edge-detected so a long strobe still yields one action.
  assign wr_evt  = sel && !IOW && iow_prev_q;
  assign rd_evt  = sel && !IOR && ior_prev_q;
  assign wr_data = wr_evt && (off == 2'd0);
  assign wr_ctrl = wr_evt && (off == 2'd1);
  assign start   = wr_ctrl && DATAIN[0] && !run_q;
  assign stop    = wr_ctrl && !DATAIN[0];
  assign flush   = wr_ctrl && DATAIN[1];

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign tick    = (state_q == COUNT) && (cnt_q == '0) && !stop;
  assign pop     = tick && !empty && !flush;
  assign push    = wr_data && (!full || pop);
  assign status  = {full, empty, underrun_q, 5'(count_q)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = COUNT;
          cnt_d   = div_q;
        end
      end
      COUNT: begin
        if (cnt_q == '0) cnt_d = div_q;
        else             cnt_d = cnt_q - 1'b1;
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    run_d      = run_q;
    div_d      = div_q;
    div_wide   = 16'(div_q);
    out_d      = out_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    underrun_d = underrun_q;
    irq_d      = run_q && (count_q <= CW'(DEPTH / 2));
    iow_prev_d = IOW;
    ior_prev_d = IOR;

    if (wr_ctrl) run_d = DATAIN[0];
    if (wr_evt && off == 2'd2) div_wide[7:0]  = DATAIN;
    if (wr_evt && off == 2'd3) div_wide[15:8] = DATAIN;
    div_d = DIV_W'(div_wide);

    if (pop) begin
      out_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = DATAIN;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    // A fresh underrun outranks a status read clearing the old one.
    if (tick && empty)               underrun_d = 1'b1;
    else if (rd_evt && off == 2'd1)  underrun_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      run_q      <= 1'b0;
      underrun_q <= 1'b0;
      irq_q      <= 1'b0;
      out_q      <= 8'h00;
      iow_prev_q <= 1'b1;
      ior_prev_q <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      run_q      <= run_d;
      underrun_q <= underrun_d;
      irq_q      <= irq_d;
      out_q      <= out_d;
      iow_prev_q <= iow_prev_d;
      ior_prev_q <= ior_prev_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    DATAOUT = 8'h00;
    if (sel && !IOR) begin
      case (off)
        2'd0:    DATAOUT = out_q;
        2'd1:    DATAOUT = status;
        2'd2:    DATAOUT = 8'(16'(div_q));
        default: DATAOUT = 8'(16'(div_q) >> 8);
      endcase
    end
  end

  assign OUT = out_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_da_stream_ctrl.sv
// tb/tb_da_stream_ctrl.sv - self-checking bench for da_stream_ctrl
// Register vectors, directed corner sequences and a random run against a queue model.
module tb_da_stream_ctrl;
  localparam logic [9:0] BASE = 10'h1F8;

  logic       CLK = 1'b0;
  logic       RST, AEN, IOR, IOW;
  logic [9:0] A;
  logic [7:0] DATAIN, DATAOUT, OUT;
  logic       IRQ;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  da_stream_ctrl #(.BASE(BASE), .DEPTH_LOG2(4), .DIV_W(16)) dut (
    .CLK(CLK), .RST(RST), .AEN(AEN), .A(A), .IOR(IOR), .IOW(IOW),
    .DATAIN(DATAIN), .DATAOUT(DATAOUT), .OUT(OUT), .IRQ(IRQ)
  );

  // Reference model: a byte queue plus the absolute cycle of the next scheduled pop.
  logic [7:0]  m_q[$];
  bit          m_run, m_under, m_irq, m_iow_prev, m_ior_prev;
  logic [15:0] m_div;
  logic [7:0]  m_out;
  longint      m_cyc, m_next;
  logic [7:0]  last_dout;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_run = 0; m_under = 0; m_irq = 0;
    m_iow_prev = 1; m_ior_prev = 1;
    m_div = 16'h0; m_out = 8'h00;
    m_cyc = 0; m_next = 0;
  endtask

  function automatic logic [7:0] m_status();
    int n;
    n = m_q.size();
    return {n == 16, n == 0, m_under, 5'(n)};
  endfunction

  function automatic logic [7:0] m_dataout();
    logic [9:0] rel;
    rel = A - BASE;
    if (!(AEN && rel < 10'd4) || IOR) return 8'h00;
    case (rel[1:0])
      2'd0:    return m_out;
      2'd1:    return m_status();
      2'd2:    return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  task automatic model_step();
    logic [9:0] rel;
    bit sel, wev, rev, ctrl, stop, flush, set_under;
    int off, old_n;
    rel   = A - BASE;
    sel   = AEN && rel < 10'd4;
    off   = int'(rel[1:0]);
    wev   = sel && !IOW && m_iow_prev;
    rev   = sel && !IOR && m_ior_prev && off == 1;
    ctrl  = wev && off == 1;
    stop  = ctrl && !DATAIN[0];
    flush = ctrl && DATAIN[1];
    old_n = m_q.size();
    set_under = 0;
    m_irq = m_run && old_n <= 8;
    if (m_run && m_cyc == m_next && !stop) begin
      if (old_n == 0) set_under = 1;
      else if (!flush) m_out = m_q.pop_front();
      m_next = m_cyc + longint'(m_div) + 1;
    end
    if (flush) m_q.delete();
    if (wev && off == 0 && m_q.size() < 16) m_q.push_back(DATAIN);
    if (set_under) m_under = 1;
    else if (rev) m_under = 0;
    if (ctrl) begin
      if (DATAIN[0] && !m_run) m_next = m_cyc + 1 + longint'(m_div);
      m_run = DATAIN[0];
    end
    if (wev && off == 2) m_div[7:0]  = DATAIN;
    if (wev && off == 3) m_div[15:8] = DATAIN;
    m_iow_prev = IOW;
    m_ior_prev = IOR;
    m_cyc++;
  endtask

  // One clock: inputs already driven; compare the read bus, advance the model, compare outputs.
  task automatic step();
    logic [7:0] exp_dout;
    #1;
    exp_dout  = m_dataout();
    last_dout = DATAOUT;
    check("dataout", DATAOUT, exp_dout);
    model_step();
    @(posedge CLK); #1;
    check("out", OUT, m_out);
    check("irq", IRQ, m_irq);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
    AEN = 1; A = BASE + 10'(off); DATAIN = d; IOW = 0;
    step();
    IOW = 1; AEN = 0;
    step();
  endtask

  task automatic bus_rd(input logic [2:0] off, output logic [7:0] v);
    AEN = 1; A = BASE + 10'(off); IOR = 0;
    step();
    v = last_dout;
    IOR = 1; AEN = 0;
    step();
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] v;
    bus_rd(off, v);
    check(name, v, exp);
  endtask

  task automatic do_reset();
    RST = 1; #1;
    check("rst_out", OUT, 8'h00);
    check("rst_irq", IRQ, 1'b0);
    @(posedge CLK); #1;
    RST = 0;
    model_reset();
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] off;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 3'd1, 8'h00, 8'h40};
    tbl[1]  = '{1'b1, 3'd2, 8'h5A, 8'h00};
    tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'h5A};
    tbl[3]  = '{1'b1, 3'd3, 8'hA5, 8'h00};
    tbl[4]  = '{1'b0, 3'd3, 8'h00, 8'hA5};
    tbl[5]  = '{1'b1, 3'd0, 8'h77, 8'h00};
    tbl[6]  = '{1'b0, 3'd1, 8'h00, 8'h01};
    tbl[7]  = '{1'b0, 3'd0, 8'h00, 8'h00};
    tbl[8]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 3'd1, 8'h02, 8'h00};
    tbl[10] = '{1'b0, 3'd1, 8'h00, 8'h40};
    tbl[11] = '{1'b1, 3'd2, 8'h00, 8'h00};
    tbl[12] = '{1'b1, 3'd3, 8'h00, 8'h00};
    tbl[13] = '{1'b0, 3'd2, 8'h00, 8'h00};

    RST = 0; AEN = 0; A = 10'h000; IOR = 1; IOW = 1; DATAIN = 8'h00;
    model_reset();
    @(posedge CLK); #1;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].off, tbl[i].data);
      else rd_chk($sformatf("tbl%0d", i), tbl[i].off, tbl[i].exp);
    end

    // Basic stream, DIV=3: pops on t0+4, t0+8, t0+12.
    do_reset();
    bus_wr(3'd2, 8'h03);
    bus_wr(3'd0, 8'h11); bus_wr(3'd0, 8'h22); bus_wr(3'd0, 8'h33);
    bus_wr(3'd1, 8'h01);
    idle(2);
    check("basic_pre", OUT, 8'h00);
    idle(1);
    check("basic_11", OUT, 8'h11);
    idle(4);
    check("basic_22", OUT, 8'h22);
    idle(4);
    check("basic_33", OUT, 8'h33);
    idle(4);
    bus_wr(3'd1, 8'h00);
    rd_chk("basic_under", 3'd1, 8'h60);
    rd_chk("basic_clear", 3'd1, 8'h40);

    // Seventeen pushes into a 16-deep FIFO, then drain at one per clock.
    do_reset();
    for (int i = 0; i < 17; i++) bus_wr(3'd0, 8'(i));
    rd_chk("full_status", 3'd1, 8'h90);
    bus_wr(3'd1, 8'h01);
    check("full_first", OUT, 8'h00);
    for (int k = 1; k < 16; k++) begin
      idle(1);
      check($sformatf("full_step%0d", k), OUT, 8'(k));
    end
    idle(3);
    check("full_no10", OUT, 8'h0F);
    rd_chk("full_drained", 3'd1, 8'h60);

    // Push landing on the pop cycle of a full FIFO.
    do_reset();
    bus_wr(3'd2, 8'h03);
    for (int i = 0; i < 16; i++) bus_wr(3'd0, 8'hA0 + 8'(i));
    bus_wr(3'd1, 8'h01);
    idle(2);
    bus_wr(3'd0, 8'h5A);
    check("conc_pop", OUT, 8'hA0);
    rd_chk("conc_full", 3'd1, 8'h90);

    // Long write strobe yields a single push.
    do_reset();
    AEN = 1; A = BASE; DATAIN = 8'hC3; IOW = 0;
    idle(5);
    IOW = 1; AEN = 0;
    idle(1);
    rd_chk("long_strobe", 3'd1, 8'h01);

    // Flush while streaming.
    do_reset();
    bus_wr(3'd2, 8'h03);
    for (int i = 0; i < 4; i++) bus_wr(3'd0, 8'hB0 + 8'(i));
    bus_wr(3'd1, 8'h01);
    idle(3);
    check("flush_pre", OUT, 8'hB0);
    bus_wr(3'd1, 8'h03);
    rd_chk("flush_count", 3'd1, 8'h40);
    rd_chk("flush_under", 3'd1, 8'h60);
    check("flush_out", OUT, 8'hB0);

    // Stop mid-period.
    do_reset();
    bus_wr(3'd2, 8'h05);
    for (int i = 0; i < 3; i++) bus_wr(3'd0, 8'hC0 + 8'(i));
    bus_wr(3'd1, 8'h01);
    idle(5);
    check("stop_pre", OUT, 8'hC0);
    bus_wr(3'd1, 8'h00);
    idle(20);
    check("stop_out", OUT, 8'hC0);
    rd_chk("stop_count", 3'd1, 8'h02);

    // IRQ threshold crossing in both directions, then reset mid-stream.
    do_reset();
    bus_wr(3'd2, 8'h03);
    for (int i = 0; i < 10; i++) bus_wr(3'd0, 8'h30 + 8'(i));
    bus_wr(3'd1, 8'h01);
    idle(7);
    check("irq_lag", IRQ, 1'b0);
    idle(1);
    check("irq_rise", IRQ, 1'b1);
    AEN = 1; A = BASE; DATAIN = 8'h99; IOW = 0;
    step();
    check("irq_hold", IRQ, 1'b1);
    IOW = 1; AEN = 0;
    step();
    check("irq_fall", IRQ, 1'b0);
    idle(2);
    check("irq_again", IRQ, 1'b1);
    do_reset();
    rd_chk("rst_status", 3'd1, 8'h40);
    check("rst_dataout", DATAOUT, 8'h00);
    rd_chk("rst_div", 3'd2, 8'h00);

    // Random bus traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int v;
      bit slow;
      logic [2:0] off;
      slow = ((c / 500) % 2) == 1;
      AEN  = ($urandom_range(0, 9) != 0);
      v    = $urandom_range(0, 9);
      off  = (v < 5) ? 3'd0 : (v < 7) ? 3'd1 : (v == 7) ? 3'd2 : (v == 8) ? 3'd3 : 3'd4;
      A    = BASE + 10'(off);
      IOW  = 1'($urandom_range(0, 1));
      IOR  = ($urandom_range(0, 3) != 0);
      case (off)
        3'd0:    DATAIN = 8'($urandom);
        3'd1:    DATAIN = {6'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0};
        3'd2:    DATAIN = slow ? 8'($urandom_range(6, 12)) : 8'($urandom_range(0, 3));
        default: DATAIN = 8'h00;
      endcase
      step();
    end
    AEN = 0; IOW = 1; IOR = 1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
